api_miner_slave: RTL and testbench

- Chip-side responder for the api serial link.
- Used as a bench/FPGA miner model, and as the front end of the on-board miner core.
- Receives work words that the API controller shifts out on load/sck/mosi, and presents them to the hashing core as a word stream.
- Returns core-found nonces on miso in the same frame, from a small nonce FIFO.

---
 rtl/api_miner_slave.sv | 217 +++++++++++++++++++++
 tb/tb_api_miner_slave.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/api_miner_slave.sv
// rtl/api_miner_slave.sv - api serial link responder: work word receiver and nonce return FIFO
module api_miner_slave #(
    parameter int          WORK_LEN    = 23,
    parameter int          NONCE_DEPTH = 4,
    parameter logic [31:0] IDLE_WORD   = 32'hFFFF_FFFF,
    localparam int         PW          = $clog2(NONCE_DEPTH),
    localparam int         CW          = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          sck,
    input  logic          mosi,
    output logic          miso,
    output logic [31:0]   work_dout,
    output logic          work_valid,
    output logic [4:0]    work_idx,
    output logic          work_done,
    output logic          work_err,
    input  logic [31:0]   nonce_din,
    input  logic          nonce_push,
    output logic          nonce_full,
    output logic [CW-1:0] nonce_cnt,
    output logic          nonce_ovf
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_END} state_t;

    localparam logic [4:0]    WL    = 5'(WORK_LEN);
    localparam logic [CW-1:0] DEPTH = CW'(NONCE_DEPTH);

    // link synchronisers and edge-detect history
    logic load_s1_q, load_s2_q, load_d_q;
    logic sck_s1_q, sck_s2_q, sck_d_q;
    logic mosi_s1_q, mosi_s2_q;

    state_t      state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [4:0]  word_cnt_q, word_cnt_d;
    logic        word_pend_q, word_pend_d;
    logic [31:0] rx_sr_q, rx_sr_d;
    logic [31:0] tx_sr_q, tx_sr_d;
    logic        miso_q, miso_d;
    logic [31:0] work_dout_q, work_dout_d;
    logic [4:0]  work_idx_q, work_idx_d;
    logic        work_valid_q, work_valid_d;
    logic        work_done_q, work_done_d;
    logic        work_err_q, work_err_d;

    logic [31:0]   mem_q [NONCE_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    logic        load_rise, load_fall, sck_rise, sck_fall;
    logic        pop_req, pop_eff, push_ok;
    logic [31:0] pop_data;

    assign load_rise = load_s2_q & ~load_d_q;
    assign load_fall = ~load_s2_q & load_d_q;
    assign sck_rise  = sck_s2_q & ~sck_d_q;
    assign sck_fall  = ~sck_s2_q & sck_d_q;

    // two-flop synchronisers plus one delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_s1_q <= 1'b0; load_s2_q <= 1'b0; load_d_q <= 1'b0;
            sck_s1_q  <= 1'b0; sck_s2_q  <= 1'b0; sck_d_q  <= 1'b0;
            mosi_s1_q <= 1'b0; mosi_s2_q <= 1'b0;
        end else begin
            load_s1_q <= load;      load_s2_q <= load_s1_q; load_d_q <= load_s2_q;
            sck_s1_q  <= sck;       sck_s2_q  <= sck_s1_q;  sck_d_q  <= sck_s2_q;
            mosi_s1_q <= mosi;      mosi_s2_q <= mosi_s1_q;
        end
    end

    // frame FSM: receive shifting, word strobes, transmit reloads and end-of-frame status
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        word_pend_d  = 1'b0;
        rx_sr_d      = rx_sr_q;
        tx_sr_d      = tx_sr_q;
        miso_d       = miso_q;
        work_dout_d  = work_dout_q;
        work_idx_d   = work_idx_q;
        work_valid_d = 1'b0;
        work_done_d  = 1'b0;
        work_err_d   = 1'b0;
        pop_req      = 1'b0;
        case (state_q)
            S_IDLE: begin
                miso_d = 1'b1;
                if (load_rise) begin
                    bit_cnt_d  = 5'd0;
                    word_cnt_d = 5'd0;
                    pop_req    = 1'b1;
                    tx_sr_d    = pop_data;
                    miso_d     = pop_data[31];
                    state_d    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // word assembled on the previous cycle; words past the frame length are dropped
                if (word_pend_q && (word_cnt_q < WL)) begin
                    work_valid_d = 1'b1;
                    work_dout_d  = rx_sr_q;
                    work_idx_d   = word_cnt_q;
                    word_cnt_d   = word_cnt_q + 5'd1;
                end
                if (sck_rise) begin
                    rx_sr_d     = {rx_sr_q[30:0], mosi_s2_q};
                    bit_cnt_d   = bit_cnt_q + 5'd1;
                    word_pend_d = (bit_cnt_q == 5'd31);
                end
                if (sck_fall) begin
                    // bit_cnt is only zero on a fall right after a word's last rise
                    if (bit_cnt_q == 5'd0) begin
                        pop_req = 1'b1;
                        tx_sr_d = pop_data;
                    end else begin
                        tx_sr_d = {tx_sr_q[30:0], tx_sr_q[31]};
                    end
                    miso_d = tx_sr_d[31];
                end
                if (load_fall) begin
                    state_d = S_END;
                end
            end
            S_END: begin
                miso_d = 1'b1;
                if ((word_cnt_q == WL) && (bit_cnt_q == 5'd0)) begin
                    work_done_d = 1'b1;
                end else begin
                    work_err_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // nonce FIFO control: an empty pop yields IDLE_WORD, a pop frees room for a same-cycle push
    always_comb begin
        pop_eff  = pop_req && (cnt_q != '0);
        pop_data = (cnt_q != '0) ? mem_q[rd_ptr_q] : IDLE_WORD;
        push_ok  = nonce_push && ((cnt_q != DEPTH) || pop_eff);
        ovf_d    = nonce_push && !push_ok;
        wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_eff ? rd_ptr_q + PW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok && !pop_eff) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!push_ok && pop_eff) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // nonce storage; contents are meaningless while cnt is zero so no reset is needed
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= nonce_din;
        end
    end

    // state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= 5'd0;
            word_cnt_q   <= 5'd0;
            word_pend_q  <= 1'b0;
            rx_sr_q      <= 32'd0;
            tx_sr_q      <= 32'd0;
            miso_q       <= 1'b1;
            work_dout_q  <= 32'd0;
            work_idx_q   <= 5'd0;
            work_valid_q <= 1'b0;
            work_done_q  <= 1'b0;
            work_err_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            word_pend_q  <= word_pend_d;
            rx_sr_q      <= rx_sr_d;
            tx_sr_q      <= tx_sr_d;
            miso_q       <= miso_d;
            work_dout_q  <= work_dout_d;
            work_idx_q   <= work_idx_d;
            work_valid_q <= work_valid_d;
            work_done_q  <= work_done_d;
            work_err_q   <= work_err_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
        end
    end

    assign miso       = miso_q;
    assign work_dout  = work_dout_q;
    assign work_idx   = work_idx_q;
    assign work_valid = work_valid_q;
    assign work_done  = work_done_q;
    assign work_err   = work_err_q;
    assign nonce_cnt  = cnt_q;
    assign nonce_full = (cnt_q == DEPTH);
    assign nonce_ovf  = ovf_q;

endmodule

// File: tb/tb_api_miner_slave.sv
// tb/tb_api_miner_slave.sv - randomized directed bench for api_miner_slave with a queue-based reference model
module tb_api_miner_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load, sck, mosi, miso;
    logic [31:0] work_dout;
    logic        work_valid, work_done, work_err;
    logic [4:0]  work_idx;
    logic [31:0] nonce_din;
    logic        nonce_push, nonce_full, nonce_ovf;
    logic [2:0]  nonce_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] mq[$];
    logic [36:0] got_q[$];
    int          n_done = 0;
    int          n_err  = 0;
    logic [31:0] tx_words[32];

    api_miner_slave dut (
        .clk(clk), .rst_n(rst_n), .load(load), .sck(sck), .mosi(mosi), .miso(miso),
        .work_dout(work_dout), .work_valid(work_valid), .work_idx(work_idx),
        .work_done(work_done), .work_err(work_err),
        .nonce_din(nonce_din), .nonce_push(nonce_push), .nonce_full(nonce_full),
        .nonce_cnt(nonce_cnt), .nonce_ovf(nonce_ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (work_valid) got_q.push_back({work_idx, work_dout});
        if (work_done)  n_done++;
        if (work_err)   n_err++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mpop();
        if (mq.size() == 0) return 32'hFFFF_FFFF;
        return mq.pop_front();
    endfunction

    task automatic push_nonce(input logic [31:0] v);
        bit exp_ovf;
        exp_ovf = (mq.size() >= 4);
        if (!exp_ovf) mq.push_back(v);
        nonce_din  = v;
        nonce_push = 1'b1;
        tick(1);
        nonce_push = 1'b0;
        chk("push_ovf", nonce_ovf, exp_ovf);
        chk("push_cnt", nonce_cnt, mq.size());
        chk("push_full", nonce_full, mq.size() == 4);
    endtask

    task automatic fill_random(input int n);
        for (int k = 0; k < n; k++) tx_words[k] = $urandom;
    endtask

    task automatic run_frame(input int nbits, input bit pstart, input logic [31:0] pval,
                             input int abort_bit, input bit chk_lat);
        int          nw_full, nw_start, n_exp, d0, e0;
        bit          exp_done;
        logic [31:0] exp_pop[32];
        int          exp_size[32];
        logic [31:0] miso_w[32];
        int          cnt_at[32];
        nw_full  = nbits / 32;
        nw_start = (nbits + 31) / 32;
        exp_pop[0] = mpop();
        if (pstart && mq.size() < 4) mq.push_back(pval);
        exp_size[0] = mq.size();
        for (int k = 1; k <= nw_full; k++) begin
            exp_pop[k]  = mpop();
            exp_size[k] = mq.size();
        end
        got_q.delete();
        d0 = n_done;
        e0 = n_err;
        for (int k = 0; k < 32; k++) begin
            miso_w[k] = 32'd0;
            cnt_at[k] = 0;
        end
        load = 1'b1;
        tick(2);
        if (pstart) begin
            nonce_din  = pval;
            nonce_push = 1'b1;
        end
        tick(1);
        nonce_push = 1'b0;
        if (pstart) begin
            chk("start_cnt", nonce_cnt, exp_size[0]);
            chk("start_ovf", nonce_ovf, 0);
        end
        tick(5);
        for (int i = 0; i < nbits; i++) begin
            int w, b;
            w = i / 32;
            b = 31 - (i % 32);
            if (i == abort_bit) begin
                rst_n = 1'b0;
                #1;
                chk("rst_miso", miso, 1);
                chk("rst_valid", work_valid, 0);
                chk("rst_dout", work_dout, 0);
                chk("rst_idx", work_idx, 0);
                chk("rst_cnt", nonce_cnt, 0);
                chk("rst_full", nonce_full, 0);
                tick(2);
                load = 1'b0;
                sck  = 1'b0;
                mosi = 1'b0;
                rst_n = 1'b1;
                mq.delete();
                tick(4);
                return;
            end
            mosi = tx_words[w][b];
            if (b == 31) cnt_at[w] = nonce_cnt;
            miso_w[w][b] = miso;
            sck = 1'b1;
            if (chk_lat && i == 31) begin
                tick(3);
                chk("lat_early", work_valid, 0);
                tick(1);
                chk("lat_4th_edge", work_valid, 1);
            end else begin
                tick(4);
            end
            sck = 1'b0;
            tick(4);
        end
        tick(4);
        load = 1'b0;
        tick(8);
        n_exp    = (nw_full < 23) ? nw_full : 23;
        exp_done = ((nbits % 32) == 0) && (nw_full >= 23);
        chk("valid_count", got_q.size(), n_exp);
        for (int k = 0; k < n_exp && k < got_q.size(); k++) begin
            chk($sformatf("work_idx[%0d]", k), got_q[k][36:32], k);
            chk($sformatf("work_dout[%0d]", k), got_q[k][31:0], tx_words[k]);
        end
        chk("work_done", n_done - d0, exp_done);
        chk("work_err", n_err - e0, !exp_done);
        for (int k = 0; k < nw_full; k++)
            chk($sformatf("miso_word[%0d]", k), miso_w[k], exp_pop[k]);
        for (int k = 0; k < nw_start; k++)
            chk($sformatf("cnt_at_word[%0d]", k), cnt_at[k], exp_size[k]);
    endtask

    initial begin
        rst_n = 1'b0;
        load = 1'b0; sck = 1'b0; mosi = 1'b0;
        nonce_din = 32'd0; nonce_push = 1'b0;
        tick(3);
        chk("reset_miso", miso, 1);
        chk("reset_dout", work_dout, 0);
        chk("reset_idx", work_idx, 0);
        chk("reset_valid", work_valid, 0);
        chk("reset_done", work_done, 0);
        chk("reset_err", work_err, 0);
        chk("reset_cnt", nonce_cnt, 0);
        chk("reset_full", nonce_full, 0);
        chk("reset_ovf", nonce_ovf, 0);
        rst_n = 1'b1;
        tick(3);

        // full frame with counting words and latency probe
        for (int k = 0; k < 32; k++) tx_words[k] = k;
        run_frame(23 * 32, 1'b0, 32'd0, -1, 1'b1);

        // nonce return
        push_nonce(32'h1234_5678);
        push_nonce(32'h9ABC_DEF0);
        fill_random(32);
        run_frame(23 * 32, 1'b0, 32'd0, -1, 1'b0);

        // short frame then a recovering full frame
        fill_random(32);
        run_frame(40, 1'b0, 32'd0, -1, 1'b0);
        fill_random(32);
        run_frame(23 * 32, 1'b0, 32'd0, -1, 1'b0);

        // overflow, then push+pop at frame start while full
        for (int k = 0; k < 5; k++) push_nonce($urandom);
        tick(1);
        chk("ovf_one_cycle", nonce_ovf, 0);
        fill_random(32);
        run_frame(23 * 32, 1'b1, $urandom, -1, 1'b0);

        // over-length frame
        fill_random(32);
        run_frame(25 * 32, 1'b0, 32'd0, -1, 1'b0);

        // async reset mid-frame, then a clean frame
        for (int k = 0; k < 4; k++) push_nonce($urandom);
        fill_random(32);
        run_frame(23 * 32, 1'b0, 32'd0, 5 * 32 + 17, 1'b0);
        fill_random(32);
        run_frame(23 * 32, 1'b0, 32'd0, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
